// File: rtl/dmem_store_buffer_pkg.sv
// Shared defaults, entry layout and address decoding for the data-memory store buffer.
package dmem_pkg;

  localparam int unsigned DEF_N         = 64;
  localparam int unsigned DEF_DEPTH     = 4;
  localparam int unsigned DEF_MEM_WORDS = 64;
  localparam int unsigned DEF_IW        = $clog2(DEF_MEM_WORDS);

  // One buffered store at the default widths: target word index plus data.
  typedef struct packed {
    logic [DEF_IW-1:0] idx;
    logic [DEF_N-1:0]  data;
  } sb_entry_t;

  // Doubleword index of a byte address; the upper bits alias modulo memWords.
  function automatic logic [31:0] word_idx(input logic [63:0] addr,
                                           input int unsigned memWords);
    logic [63:0] w;
    w = addr >> 3;
    return 32'(w) & (memWords - 1);
  endfunction

endpackage

// File: rtl/dmem_store_buffer_if.sv
// MEM-stage request/response bundle between the datapath and the data memory.
interface dmem_store_buffer_if #(
  parameter int unsigned N     = dmem_pkg::DEF_N,
  parameter int unsigned DEPTH = dmem_pkg::DEF_DEPTH
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [N-1:0]  DM_addr;
  logic [N-1:0]  DM_writeData;
  logic          DM_writeEnable;
  logic          DM_readEnable;
  logic [N-1:0]  DM_readData;
  logic          stall;
  logic [CW-1:0] sb_count;

  modport master (
    output DM_addr, DM_writeData, DM_writeEnable, DM_readEnable,
    input  DM_readData, stall, sb_count
  );

  modport slave (
    input  DM_addr, DM_writeData, DM_writeEnable, DM_readEnable,
    output DM_readData, stall, sb_count
  );

endinterface

// File: rtl/dmem_store_buffer_sb_fifo.sv
// In-order store buffer: circular entry array with head/tail/count and a
// youngest-match lookup used for store-to-load forwarding.
module sb_fifo #(
  parameter int unsigned N     = dmem_pkg::DEF_N,
  parameter int unsigned DEPTH = dmem_pkg::DEF_DEPTH,
  parameter int unsigned IW    = dmem_pkg::DEF_IW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq,
  input  logic [IW-1:0]              enqIdx,
  input  logic [N-1:0]               enqData,
  input  logic                       deq,
  input  logic [IW-1:0]              lookupIdx,
  output logic [IW-1:0]              headIdx,
  output logic [N-1:0]               headData,
  output logic                       hit,
  output logic [N-1:0]               hitData,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [N-1:0]  data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          enqOk;
  logic          deqOk;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign enqOk    = enq && !full;
  assign deqOk    = deq && !empty;
  assign headIdx  = mem[head].idx;
  assign headData = mem[head].data;

  // Pointer/count update; entries beyond count are treated as invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enqOk) begin
        mem[tail] <= '{idx: enqIdx, data: enqData};
        tail      <= tail + 1'b1;
      end
      if (deqOk) begin
        head <= head + 1'b1;
      end
      count <= count + CW'(enqOk) - CW'(deqOk);
    end
  end

  // Walk oldest to youngest so the last valid match is the youngest store.
  always_comb begin
    logic [PW-1:0] pos;
    hit     = 1'b0;
    hitData = '0;
    pos     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      pos = head + PW'(k);
      if ((CW'(k) < count) && (mem[pos].idx == lookupIdx)) begin
        hit     = 1'b1;
        hitData = mem[pos].data;
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Data memory behind the MEM stage: store buffer draining into a word RAM,
// with combinational loads forwarded from the youngest buffered store.
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int unsigned N         = DEF_N,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_store_buffer_if.slave    dmBus
);

  localparam int unsigned IW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [N-1:0]  ram [MEM_WORDS];
  logic [IW-1:0] wordIdx;
  logic [IW-1:0] headIdx;
  logic [N-1:0]  headData;
  logic          hit;
  logic [N-1:0]  hitData;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          enq;
  logic          drain;

  assign wordIdx = IW'(word_idx(64'(dmBus.DM_addr), MEM_WORDS));

  // A full buffer drains even under a load so a held store can always get in.
  assign drain          = !empty && (!dmBus.DM_readEnable || full);
  assign enq            = dmBus.DM_writeEnable && !full;
  assign dmBus.stall    = dmBus.DM_writeEnable && full;
  assign dmBus.sb_count = count;

  sb_fifo #(
    .N     (N),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) fifo (
    .clk       (clk),
    .reset     (reset),
    .enq       (enq),
    .enqIdx    (wordIdx),
    .enqData   (dmBus.DM_writeData),
    .deq       (drain),
    .lookupIdx (wordIdx),
    .headIdx   (headIdx),
    .headData  (headData),
    .hit       (hit),
    .hitData   (hitData),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Single write port: cleared on reset, otherwise takes the drained head entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < MEM_WORDS; i++) begin
        ram[i] <= '0;
      end
    end else if (drain) begin
      ram[headIdx] <= headData;
    end
  end

  // Load mux on pre-edge state; an incoming store this cycle is not bypassed.
  always_comb begin
    dmBus.DM_readData = '0;
    if (dmBus.DM_readEnable) begin
      dmBus.DM_readData = hit ? hitData : ram[wordIdx];
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer with a queue of expected outputs.
module tb_dmem_store_buffer;

  localparam int unsigned N     = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MW    = 64;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];

  dmem_store_buffer_if #(.N(N), .DEPTH(DEPTH)) dmBus ();

  dmem_store_buffer #(.N(N), .DEPTH(DEPTH), .MEM_WORDS(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .dmBus (dmBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pushExp(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic popCheck(input logic [63:0] obs);
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  // One clock cycle: drive request, sample at negedge, then advance past posedge.
  task automatic step(input string tag, input logic we, input logic re,
                      input logic [63:0] addr, input logic [63:0] data,
                      input logic [63:0] expRd, input int expCnt, input logic expStall);
    dmBus.DM_writeEnable = we;
    dmBus.DM_readEnable  = re;
    dmBus.DM_addr        = addr;
    dmBus.DM_writeData   = data;
    pushExp({tag, ".rd"}, expRd);
    pushExp({tag, ".cnt"}, 64'(expCnt));
    pushExp({tag, ".stall"}, 64'(expStall));
    @(negedge clk);
    popCheck(dmBus.DM_readData);
    popCheck(64'(dmBus.sb_count));
    popCheck(64'(dmBus.stall));
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset                = 1'b1;
    dmBus.DM_writeEnable = 1'b0;
    dmBus.DM_readEnable  = 1'b0;
    dmBus.DM_addr        = '0;
    dmBus.DM_writeData   = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    dmBus.DM_writeEnable = 1'b0;
    dmBus.DM_readEnable  = 1'b0;
    dmBus.DM_addr        = '0;
    dmBus.DM_writeData   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    step("rst_load",   0, 1, 64'h10, 0, 64'h0, 0, 0);

    // Single store, forwarded then drained into RAM.
    step("st_dead",    1, 0, 64'h08, 64'hDEAD, 64'h0, 0, 0);
    step("fwd_dead0",  0, 1, 64'h08, 0, 64'hDEAD, 1, 0);
    step("fwd_dead1",  0, 1, 64'h08, 0, 64'hDEAD, 1, 0);
    step("drain_gap",  0, 0, 64'h08, 0, 64'h0, 1, 0);
    step("ram_dead",   0, 1, 64'h08, 0, 64'hDEAD, 0, 0);

    // Two stores to one word under loads: youngest wins, no same-cycle bypass.
    step("st1_0x20",   1, 1, 64'h20, 64'h1, 64'h0, 0, 0);
    step("st2_0x20",   1, 1, 64'h20, 64'h2, 64'h1, 1, 0);
    step("young_0x20", 0, 1, 64'h20, 0, 64'h2, 2, 0);
    step("drainA",     0, 0, 64'h0, 0, 64'h0, 2, 0);
    step("drainB",     0, 0, 64'h0, 0, 64'h0, 1, 0);
    step("ram_0x20",   0, 1, 64'h20, 0, 64'h2, 0, 0);

    // Fill the buffer under loads, then a stalled fifth store.
    step("fill0",      1, 1, 64'h40, 64'h10, 64'h0,  0, 0);
    step("fill1",      1, 1, 64'h40, 64'h11, 64'h10, 1, 0);
    step("fill2",      1, 1, 64'h40, 64'h12, 64'h11, 2, 0);
    step("fill3",      1, 1, 64'h40, 64'h13, 64'h12, 3, 0);
    step("full_stall", 1, 1, 64'h48, 64'h5,  64'h0,  4, 1);
    step("held_acc",   1, 1, 64'h48, 64'h5,  64'h0,  3, 0);
    step("fwd_0x48",   0, 1, 64'h48, 0, 64'h5,  4, 0);
    step("fwd_0x40",   0, 1, 64'h40, 0, 64'h13, 3, 0);

    // Reset with three buffered stores discards them and clears RAM.
    doReset();
    step("post_rst40", 0, 1, 64'h40, 0, 64'h0, 0, 0);
    step("post_rst48", 0, 1, 64'h48, 0, 64'h0, 0, 0);
    step("post_rst08", 0, 1, 64'h08, 0, 64'h0, 0, 0);
    step("post_rst20", 0, 1, 64'h20, 0, 64'h0, 0, 0);

    // Address aliasing: high bits and low three bits ignored.
    step("st_0x200",   1, 0, 64'h200, 64'h77, 64'h0, 0, 0);
    step("alias_fwd",  0, 1, 64'h000, 0, 64'h77, 1, 0);
    step("alias_drn",  0, 0, 64'h000, 0, 64'h0, 1, 0);
    step("alias_ram",  0, 1, 64'h000, 0, 64'h77, 0, 0);
    step("st_0x0B",    1, 0, 64'h0B, 64'hABC, 64'h0, 0, 0);
    step("lo_alias",   0, 1, 64'h08, 0, 64'hABC, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
